// File: rtl/pipelined_leading_zero_counter_if.sv
// rtl/pipelined_leading_zero_counter_if.sv - operand/result handshake bundle for the zero counter
interface pipelined_leading_zero_counter_if #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 4,
  parameter int CW        = $clog2(WIDTH) + 1
);
  logic                 inValid;
  logic                 inReady;
  logic [WIDTH-1:0]     inData;
  logic                 inTrailing;
  logic [TAG_WIDTH-1:0] inTag;
  logic                 outValid;
  logic                 outReady;
  logic [CW-1:0]        outCount;
  logic                 outZero;
  logic [TAG_WIDTH-1:0] outTag;

  modport master (
    output inValid, inData, inTrailing, inTag, outReady,
    input  inReady, outValid, outCount, outZero, outTag
  );

  modport slave (
    input  inValid, inData, inTrailing, inTag, outReady,
    output inReady, outValid, outCount, outZero, outTag
  );
endinterface

// File: rtl/pipelined_leading_zero_counter.sv
// rtl/pipelined_leading_zero_counter.sv - pipelined leading/trailing zero counter, one register per tree level
module pipelined_leading_zero_counter #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 4
) (
  input logic                             clock,
  input logic                             resetN,
  pipelined_leading_zero_counter_if.slave bus
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int CW     = LEVELS + 1;

  logic             advance;
  logic [WIDTH-1:0] operand;

  // Trailing mode bit-reverses the operand so the tree only ever counts leading zeros;
  // the mode is fully consumed here, so only the tag travels down the pipeline.
  always_comb begin
    operand = bus.inData;
    if (bus.inTrailing) begin
      for (int i = 0; i < WIDTH; i++) begin
        operand[i] = bus.inData[WIDTH-1-i];
      end
    end
  end

  // One global enable: the whole pipe moves unless a result is parked at the output.
  assign advance     = !bus.outValid || bus.outReady;
  assign bus.inReady = advance;

  for (genvar s = 1; s <= LEVELS; s++) begin : gLevel
    localparam int FW = s + 1;          // field width produced by this level
    localparam int NF = WIDTH >> s;     // number of fields produced by this level

    logic [NF*FW-1:0]     nextData;
    logic [NF*FW-1:0]     dataQ;
    logic                 prevValid;
    logic                 validQ;
    logic [TAG_WIDTH-1:0] prevTag;
    logic [TAG_WIDTH-1:0] tagQ;

    if (s == 1) begin : gEncode
      assign prevValid = bus.inValid;
      assign prevTag   = bus.inTag;

      // Pair encode: 00 = high bit set, 01 = only low bit set, 10 = both clear.
      always_comb begin
        nextData = '0;
        for (int f = 0; f < NF; f++) begin
          nextData[2*f+1] = ~operand[2*f+1] & ~operand[2*f];
          nextData[2*f]   = ~operand[2*f+1] &  operand[2*f];
        end
      end
    end else begin : gAggregate
      localparam int W = s;             // predecessor field width
      logic [2*NF*W-1:0] prevData;
      logic [W-1:0]      leftF;
      logic [W-1:0]      rightF;

      assign prevValid = gLevel[s-1].validQ;
      assign prevTag   = gLevel[s-1].tagQ;
      assign prevData  = gLevel[s-1].dataQ;

      // A field MSB means "this half is all zero"; merge left (upper) and right halves.
      always_comb begin
        nextData = '0;
        leftF    = '0;
        rightF   = '0;
        for (int f = 0; f < NF; f++) begin
          leftF  = prevData[(2*f+1)*W +: W];
          rightF = prevData[(2*f)*W +: W];
          if (leftF[W-1] && rightF[W-1]) begin
            nextData[f*FW +: FW] = {1'b1, {W{1'b0}}};
          end else if (leftF[W-1]) begin
            nextData[f*FW +: FW] = {2'b01, rightF[W-2:0]};
          end else begin
            nextData[f*FW +: FW] = {1'b0, leftF};
          end
        end
      end
    end

    // Level register: loads from its predecessor on advance, bubbles included.
    always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
        validQ <= 1'b0;
        dataQ  <= '0;
        tagQ   <= '0;
      end else if (advance) begin
        validQ <= prevValid;
        dataQ  <= nextData;
        tagQ   <= prevTag;
      end
    end
  end

  assign bus.outValid = gLevel[LEVELS].validQ;
  assign bus.outCount = gLevel[LEVELS].dataQ;
  assign bus.outZero  = gLevel[LEVELS].dataQ[CW-1];
  assign bus.outTag   = gLevel[LEVELS].tagQ;
endmodule
